// File: rtl/sonic_vc_ta_pkg.sv
// rtl/sonic_vc_ta_pkg.sv - shared constants and width helpers for the RL timing adapter
package sonic_vc_ta_pkg;

  localparam int IN_RL_MAX = 3;

  // Stored beat is {data, error, sop, eop, empty}.
  function automatic int payload_w(input int data_w, input int empty_w);
    return data_w + empty_w + 3;
  endfunction

  // One extra bit so a full FIFO (fill == depth) is representable.
  function automatic int fill_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sonic_vc_ta_fifo.sv
// rtl/sonic_vc_ta_fifo.sv - show-ahead FIFO with registered fill level and unreset storage
module sonic_vc_ta_fifo
  import sonic_vc_ta_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_data,
  output logic [fill_w(DEPTH)-1:0]  fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = fill_w(DEPTH);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign do_pop  = pop & (fill_level != '0);
  assign do_push = push & ((fill_level != FULL) | do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/sonic_vc_rl_timing_adapter.sv
// rtl/sonic_vc_rl_timing_adapter.sv - ready-latency adapter (sink RL=IN_RL, source RL=0) over a show-ahead FIFO
// Optional sticky overflow flag enabled by defining SONIC_VC_TA_OVERFLOW_EN.
module sonic_vc_rl_timing_adapter
  import sonic_vc_ta_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int EMPTY_W = 4,
  parameter int DEPTH   = 8,
  parameter int IN_RL   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      in_ready,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_error,
  input  logic                      in_startofpacket,
  input  logic                      in_endofpacket,
  input  logic [EMPTY_W-1:0]        in_empty,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_error,
  output logic                      out_startofpacket,
  output logic                      out_endofpacket,
  output logic [EMPTY_W-1:0]        out_empty,
  output logic [fill_w(DEPTH)-1:0]  fill_level
`ifdef SONIC_VC_TA_OVERFLOW_EN
  ,
  output logic                      overflow
`endif
);

  localparam int PW = payload_w(DATA_W, EMPTY_W);
  localparam int FW = fill_w(DEPTH);
  localparam logic [FW-1:0] READY_MAX = FW'(DEPTH - 1 - IN_RL);

  if (IN_RL > IN_RL_MAX || IN_RL < 0) begin : g_bad_rl
    $error("IN_RL out of range");
  end
  if (DEPTH < IN_RL + 2) begin : g_bad_depth
    $error("DEPTH too small for IN_RL");
  end

  logic          push;
  logic          pop;
  logic [PW-1:0] push_payload;
  logic [PW-1:0] pop_payload;

  // Leave room for the IN_RL beats that may still arrive after ready drops.
  assign in_ready  = (fill_level <= READY_MAX);
  assign out_valid = (fill_level != '0);
  assign pop       = out_valid & out_ready;

  if (IN_RL == 0) begin : g_rl0
    assign push = in_valid & in_ready;
  end else begin : g_rln
    assign push = in_valid;
  end

  assign push_payload = {in_data, in_error, in_startofpacket, in_endofpacket, in_empty};
  assign {out_data, out_error, out_startofpacket, out_endofpacket, out_empty} = pop_payload;

  sonic_vc_ta_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_payload),
    .pop        (pop),
    .pop_data   (pop_payload),
    .fill_level (fill_level)
  );

`ifdef SONIC_VC_TA_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push && (fill_level == FW'(DEPTH)) && !pop) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sonic_vc_rl_timing_adapter.sv
// tb/tb_sonic_vc_rl_timing_adapter.sv - scoreboard bench: IN_RL=1/DEPTH=8 directed+random, IN_RL=0/DEPTH=4 random
module tb_sonic_vc_rl_timing_adapter;

  typedef struct packed {
    logic [127:0] data;
    logic         err;
    logic         sop;
    logic         eop;
    logic [3:0]   empty;
  } beat_t;

  localparam int A_DEPTH = 8;
  localparam int A_RL    = 1;
  localparam int B_DEPTH = 4;
  localparam int B_RL    = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance A
  logic         a_reset = 1'b1;
  logic         a_in_ready, a_in_valid = 1'b0, a_out_ready = 1'b0, a_out_valid;
  beat_t        a_in = '0;
  logic [127:0] a_out_data;
  logic         a_out_error, a_out_sop, a_out_eop;
  logic [3:0]   a_out_empty;
  logic [3:0]   a_fill;
  // Instance B
  logic         b_reset = 1'b1;
  logic         b_in_ready, b_in_valid = 1'b0, b_out_ready = 1'b0, b_out_valid;
  beat_t        b_in = '0;
  logic [127:0] b_out_data;
  logic         b_out_error, b_out_sop, b_out_eop;
  logic [3:0]   b_out_empty;
  logic [2:0]   b_fill;
`ifdef SONIC_VC_TA_OVERFLOW_EN
  logic         a_overflow, b_overflow;
`endif

  sonic_vc_rl_timing_adapter #(.DATA_W(128), .EMPTY_W(4), .DEPTH(A_DEPTH), .IN_RL(A_RL)) u_dut_a (
    .clk(clk), .reset(a_reset), .in_ready(a_in_ready), .in_valid(a_in_valid),
    .in_data(a_in.data), .in_error(a_in.err), .in_startofpacket(a_in.sop),
    .in_endofpacket(a_in.eop), .in_empty(a_in.empty),
    .out_ready(a_out_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_error(a_out_error), .out_startofpacket(a_out_sop), .out_endofpacket(a_out_eop),
    .out_empty(a_out_empty), .fill_level(a_fill)
`ifdef SONIC_VC_TA_OVERFLOW_EN
    , .overflow(a_overflow)
`endif
  );

  sonic_vc_rl_timing_adapter #(.DATA_W(128), .EMPTY_W(4), .DEPTH(B_DEPTH), .IN_RL(B_RL)) u_dut_b (
    .clk(clk), .reset(b_reset), .in_ready(b_in_ready), .in_valid(b_in_valid),
    .in_data(b_in.data), .in_error(b_in.err), .in_startofpacket(b_in.sop),
    .in_endofpacket(b_in.eop), .in_empty(b_in.empty),
    .out_ready(b_out_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_error(b_out_error), .out_startofpacket(b_out_sop), .out_endofpacket(b_out_eop),
    .out_empty(b_out_empty), .fill_level(b_fill)
`ifdef SONIC_VC_TA_OVERFLOW_EN
    , .overflow(b_overflow)
`endif
  );

  // Reference model: accepted-beat queues plus occupancy counters.
  beat_t exp_a[$];
  beat_t exp_b[$];
  beat_t a_exp_beat, b_exp_beat;
  int    a_mfill = 0, b_mfill = 0;
  bit    a_movf = 0;
  bit    a_last_ready = 1;
  int    b_acc_cnt = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.data  = {$urandom, $urandom, $urandom, $urandom};
    b.err   = 1'($urandom);
    b.sop   = 1'($urandom);
    b.eop   = 1'($urandom);
    b.empty = 4'($urandom);
    return b;
  endfunction

  always @(negedge clk) begin
    if (a_reset === 1'b0 && a_out_valid && a_out_ready) begin
      if (exp_a.size() == 0) begin
        chk("a_unexpected_beat", a_out_valid, 1'b0);
      end else begin
        a_exp_beat = exp_a.pop_front();
        chk("a_beat", {a_out_data, a_out_error, a_out_sop, a_out_eop, a_out_empty}, a_exp_beat);
      end
    end
    if (b_reset === 1'b0 && b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) begin
        chk("b_unexpected_beat", b_out_valid, 1'b0);
      end else begin
        b_exp_beat = exp_b.pop_front();
        chk("b_beat", {b_out_data, b_out_error, b_out_sop, b_out_eop, b_out_empty}, b_exp_beat);
      end
    end
  end

  // Entered 1 time unit after a rising edge; checks state, drives one cycle, advances.
  task automatic a_step(input bit v, input bit r, input beat_t b);
    bit pop, acc;
    chk("a_fill", a_fill, a_mfill);
    chk("a_in_ready", a_in_ready, a_mfill <= A_DEPTH - 1 - A_RL);
    chk("a_out_valid", a_out_valid, a_mfill != 0);
`ifdef SONIC_VC_TA_OVERFLOW_EN
    chk("a_overflow", a_overflow, a_movf);
`endif
    a_last_ready = (a_mfill <= A_DEPTH - 1 - A_RL);
    a_in_valid  = v;
    a_in        = b;
    a_out_ready = r;
    pop = r && (a_mfill != 0);
    acc = v && (a_mfill < A_DEPTH || pop);
    if (acc) exp_a.push_back(b);
    if (v && !acc) a_movf = 1;
    a_mfill = a_mfill + int'(acc) - int'(pop);
    @(posedge clk);
    #1;
  endtask

  task automatic a_reset_cycles(input int n);
    a_reset     = 1'b1;
    a_in_valid  = 1'b1;
    a_out_ready = 1'b1;
    a_in        = rand_beat();
    exp_a.delete();
    repeat (n) @(posedge clk);
    #1;
    a_reset     = 1'b0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    a_mfill      = 0;
    a_movf       = 0;
    a_last_ready = 1;
  endtask

  task automatic b_step(input bit v, input bit r, input beat_t b);
    bit pop, acc;
    chk("b_fill", b_fill, b_mfill);
    chk("b_in_ready", b_in_ready, b_mfill <= B_DEPTH - 1 - B_RL);
    chk("b_out_valid", b_out_valid, b_mfill != 0);
`ifdef SONIC_VC_TA_OVERFLOW_EN
    chk("b_overflow", b_overflow, 1'b0);
`endif
    b_in_valid  = v;
    b_in        = b;
    b_out_ready = r;
    pop = r && (b_mfill != 0);
    acc = v && (b_mfill <= B_DEPTH - 1 - B_RL);
    if (acc) begin
      exp_b.push_back(b);
      b_acc_cnt++;
    end
    b_mfill = b_mfill + int'(acc) - int'(pop);
    @(posedge clk);
    #1;
  endtask

  task automatic flow_a();
    beat_t b;
    a_reset_cycles(2);
    // single beat through an empty FIFO
    b = '0;
    b.data = 128'h1; b.sop = 1'b1; b.eop = 1'b1; b.empty = 4'd3;
    a_step(1, 1, b);
    a_step(0, 1, rand_beat());
    a_step(0, 1, rand_beat());
    // fill with a stalled sink while honoring the ready latency
    repeat (12) a_step(a_last_ready, 0, rand_beat());
    // full FIFO with push and pop every cycle
    repeat (20) a_step(1, 1, rand_beat());
    repeat (9) a_step(0, 1, rand_beat());
    repeat (2000) a_step(a_last_ready && ($urandom_range(3) != 0), 1'($urandom_range(1)), rand_beat());
    // forced push into a full FIFO is dropped
    repeat (12) a_step(a_last_ready, 0, rand_beat());
    a_step(1, 0, rand_beat());
    repeat (3) a_step(0, 0, rand_beat());
    repeat (9) a_step(0, 1, rand_beat());
    // reset with five beats of an open packet stored
    for (int i = 0; i < 5; i++) begin
      b = rand_beat();
      b.sop = (i == 0);
      b.eop = 1'b0;
      a_step(1, 0, b);
    end
    a_step(0, 0, rand_beat());
    a_reset_cycles(1);
    a_step(0, 0, rand_beat());
    a_step(1, 1, rand_beat());
    a_step(0, 1, rand_beat());
    a_step(0, 1, rand_beat());
    chk("a_sb_drained", exp_a.size(), 0);
  endtask

  task automatic flow_b();
    int cyc = 0;
    b_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    b_reset = 1'b0;
    while (b_acc_cnt < 10000 && cyc < 40000) begin
      b_step($urandom_range(3) != 0, 1'($urandom_range(1)), rand_beat());
      cyc++;
    end
    chk("b_beats_pushed", b_acc_cnt >= 10000, 1'b1);
    repeat (6) b_step(0, 1, rand_beat());
    chk("b_sb_drained", exp_b.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      flow_a();
      flow_b();
    join
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
